// File: rtl/mul32_iter.sv
// Iterative WIDTH x WIDTH -> 2*WIDTH signed/unsigned multiplier (radix-4 shift-add plus sign fix-up).
// Latency: accept edge e0 -> out_en high after edge e0+WIDTH/2+1; accept-to-accept WIDTH/2+2 edges.
// Backpressure: single op in flight; in_en is sampled only while idle=1, busy-time requests are dropped.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_en               operation request (accepted only while idle=1)
//   a, b                operands, sampled on the accept edge only
//   a_signed, b_signed  per-operand two's complement select
//   out_en              one-cycle pulse: sum_hi/sum_lo hold a new product
//   idle                ready to accept in_en on the next rising edge
//   sum_hi, sum_lo      product bits [2W-1:W] and [W-1:0], held until the next result or reset
module mul32_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             a_signed,
  input  logic             b_signed,
  output logic             out_en,
  output logic             idle,
  output logic [WIDTH-1:0] sum_hi,
  output logic [WIDTH-1:0] sum_lo
);

  localparam int W     = WIDTH;
  localparam int STEPS = W / 2;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_mag_q, a_mag_d;    // |a|, consumed two bits per step from the LSB end
  logic [W-1:0]    b_mag_q, b_mag_d;    // |b|
  logic [W+1:0]    b3_q, b3_d;          // 3*|b|, precomputed so each step is a single add
  logic            neg_q, neg_d;        // product sign
  logic [2*W+1:0]  acc_q, acc_d;        // partial product; W+2 headroom bits above the window
  logic [CW-1:0]   count_q, count_d;
  logic            out_en_q, out_en_d;
  logic [2*W-1:0]  sum_q, sum_d;

  // Combinational helpers
  logic            a_neg, b_neg;
  logic [W-1:0]    a_abs, b_abs;
  logic [W+1:0]    addend;
  logic [W+2:0]    acc_top_sum;
  logic [2*W-1:0]  prod;

  always_comb begin
    a_neg = a_signed & a[W-1];
    b_neg = b_signed & b[W-1];
    // Negating the most negative value wraps back onto itself, which is the
    // correct unsigned magnitude (2^(W-1)).
    a_abs = a_neg ? (~a + 1'b1) : a;
    b_abs = b_neg ? (~b + 1'b1) : b;
  end

  // Radix-4 digit select: the two LSBs of |a| choose 0, 1x, 2x or 3x of |b|.
  always_comb begin
    unique case (a_mag_q[1:0])
      2'd0:    addend = '0;
      2'd1:    addend = {2'b00, b_mag_q};
      2'd2:    addend = {1'b0, b_mag_q, 1'b0};
      default: addend = b3_q;
    endcase
    // Upper bits of the accumulator stay below 2^W before the add, so
    // one extra carry bit is all the sum needs.
    acc_top_sum = {1'b0, acc_q[2*W+1:W]} + {1'b0, addend};
    prod        = acc_q[2*W-1:0];
  end

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    b3_d     = b3_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    count_d  = count_q;
    out_en_d = 1'b0;
    sum_d    = sum_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_en) begin
          a_mag_d = a_abs;
          b_mag_d = b_abs;
          b3_d    = {2'b00, b_abs} + {1'b0, b_abs, 1'b0};
          neg_d   = a_neg ^ b_neg;
          acc_d   = '0;
          count_d = CW'(STEPS - 1);
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        // Add into the top, then shift the whole accumulator right by 2.
        // The two bits dropped off the bottom are always zero before the
        // final step, so nothing is lost.
        acc_d   = {1'b0, acc_top_sum, acc_q[W-1:2]};
        a_mag_d = a_mag_q >> 2;
        count_d = count_q - CW'(1);
        if (count_q == '0) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        sum_d    = neg_q ? (~prod + 1'b1) : prod;
        out_en_d = 1'b1;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      b3_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      count_q  <= '0;
      out_en_q <= 1'b0;
      sum_q    <= '0;
    end else begin
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      b3_q     <= b3_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      out_en_q <= out_en_d;
      sum_q    <= sum_d;
    end
  end

  assign idle   = (state_q == S_IDLE);
  assign out_en = out_en_q;
  assign sum_hi = sum_q[2*W-1:W];
  assign sum_lo = sum_q[W-1:0];

endmodule
